// File: rtl/change_stamp_pkg.sv
// Shared types and helpers for the change_stamp_monitor block.
package change_stamp_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_TS_W   = 32;

  // Log entry as seen by consumers of a default-width monitor.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_TS_W-1:0]   ts;
    logic                  wrap;
  } change_stamp_entry_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/change_stamp_fifo.sv
// Synchronous DEPTH-entry FIFO; pointers carry an extra MSB to split full from empty.
module change_stamp_fifo
  import change_stamp_pkg::*;
#(
  parameter int unsigned W     = 65,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [W-1:0]              din_i,
  output logic [W-1:0]              dout_o,
  output logic                      valid_o,
  output logic                      full_o,
  output logic [level_w(DEPTH)-1:0] level_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = level_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW:0]   wr_q, rd_q;
  logic [LW-1:0] cnt_q;

  assign valid_o = (wr_q != rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign level_o = cnt_q;
  // Head entry is a stored register; forced to zero while empty.
  assign dout_o  = valid_o ? mem_q[rd_q[PW-1:0]] : '0;

  // Entry storage; callers only push when there is room this cycle.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[PW-1:0]] <= din_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (PW+1)'(1);
      if (pop_i)  rd_q <= rd_q + (PW+1)'(1);
      cnt_q <= cnt_q + LW'(push_i) - LW'(pop_i);
    end
  end

endmodule

// File: rtl/change_stamp_monitor.sv
// Change logger: records each new sampled value with a fixed-point timestamp.
// Optional drop counter enabled by defining CHANGE_STAMP_DROP_CNT_EN.
module change_stamp_monitor
  import change_stamp_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TS_W        = 32,
  parameter int unsigned FRAC_DIGITS = 2,
  parameter int unsigned TICK_INC    = 552,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DROP_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ts_en,
  input  logic                      ts_clear,
  input  logic                      sample_valid,
  input  logic [DATA_W-1:0]         sample_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [TS_W-1:0]           out_ts,
  output logic                      out_wrap,
  output logic [TS_W-1:0]           ts_now,
  output logic [level_w(DEPTH)-1:0] fifo_level
`ifdef CHANGE_STAMP_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0]         drop_count
`endif
);

  localparam int unsigned TSW1 = TS_W + 1;
  localparam int unsigned EW   = DATA_W + TS_W + 1;

  // Reject parameter sets the datapath cannot honour.
  if (TICK_INC == 0 || (TS_W < 32 && (TICK_INC >> TS_W) != 0) || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || DROP_W == 0 || FRAC_DIGITS > 18) begin : g_bad_cfg
    $error("change_stamp_monitor: unsupported parameter set");
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
    logic              wrap;
  } entry_t;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic              wrap_q, wrap_d;
  logic              armed_q, armed_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [TS_W:0]     inc_sum;
  logic              wrap_set, change, pop, accept, fifo_full;
  entry_t            push_entry, head;

  assign pop = out_valid && out_ready;

  // Timestamp advance, change detection and wrap-flag capture.
  always_comb begin
    ts_d       = ts_q;
    wrap_set   = 1'b0;
    inc_sum    = {1'b0, ts_q} + TSW1'(TICK_INC);
    change     = sample_valid && (armed_q || (sample_in != last_q));
    accept     = change && (!fifo_full || pop);
    push_entry = '{data: sample_in, ts: ts_q, wrap: wrap_q};
    if (ts_clear) begin
      ts_d     = '0;
      wrap_set = 1'b1;
    end else if (ts_en) begin
      ts_d     = inc_sum[TS_W-1:0];
      wrap_set = inc_sum[TS_W];
    end
    // A logged entry consumes the flag; a wrap in the same cycle re-arms it.
    wrap_d  = (accept ? 1'b0 : wrap_q) | wrap_set;
    armed_d = armed_q && !change;
    last_d  = change ? sample_in : last_q;
  end

  // Monitor state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q    <= '0;
      wrap_q  <= 1'b0;
      armed_q <= 1'b1;
      last_q  <= '0;
    end else begin
      ts_q    <= ts_d;
      wrap_q  <= wrap_d;
      armed_q <= armed_d;
      last_q  <= last_d;
    end
  end

  change_stamp_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .din_i   (push_entry),
    .dout_o  (head),
    .valid_o (out_valid),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign out_data = head.data;
  assign out_ts   = head.ts;
  assign out_wrap = head.wrap;
  assign ts_now   = ts_q;

`ifdef CHANGE_STAMP_DROP_CNT_EN
  logic [DROP_W-1:0] drop_q;

  // Saturating count of changes lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (change && !accept && (drop_q != '1)) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_change_stamp_monitor.sv
// Randomized bench for change_stamp_monitor with a queue-based reference model.
module tb_change_stamp_monitor;
  import change_stamp_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TS_W   = 32;
  localparam int unsigned TICK   = 552;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned LW     = level_w(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default parameters)
  logic              rst, ts_en, ts_clear, sample_valid, out_ready;
  logic [DATA_W-1:0] sample_in;
  logic              out_valid, out_wrap;
  logic [DATA_W-1:0] out_data;
  logic [TS_W-1:0]   out_ts, ts_now;
  logic [LW-1:0]     fifo_level;
`ifdef CHANGE_STAMP_DROP_CNT_EN
  logic [DROP_W-1:0] drop_count;
`endif

  change_stamp_monitor u_dut (
    .clk          (clk),
    .rst          (rst),
    .ts_en        (ts_en),
    .ts_clear     (ts_clear),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ts       (out_ts),
    .out_wrap     (out_wrap),
    .ts_now       (ts_now),
    .fifo_level   (fifo_level)
`ifdef CHANGE_STAMP_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  // Narrow-timestamp DUT for wrap behaviour
  logic              s_rst, s_en, s_clear, s_valid, s_ready;
  logic [DATA_W-1:0] s_in;
  logic              s_out_valid, s_out_wrap;
  logic [DATA_W-1:0] s_out_data;
  logic [9:0]        s_out_ts, s_ts_now;
  logic [LW-1:0]     s_level;
`ifdef CHANGE_STAMP_DROP_CNT_EN
  logic [DROP_W-1:0] s_drop;
`endif

  change_stamp_monitor #(.TS_W(10)) u_dut10 (
    .clk          (clk),
    .rst          (s_rst),
    .ts_en        (s_en),
    .ts_clear     (s_clear),
    .sample_valid (s_valid),
    .sample_in    (s_in),
    .out_valid    (s_out_valid),
    .out_ready    (s_ready),
    .out_data     (s_out_data),
    .out_ts       (s_out_ts),
    .out_wrap     (s_out_wrap),
    .ts_now       (s_ts_now),
    .fifo_level   (s_level)
`ifdef CHANGE_STAMP_DROP_CNT_EN
    ,
    .drop_count   (s_drop)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: log as a queue, timestamp as plain integer arithmetic.
  typedef struct {
    logic [DATA_W-1:0] data;
    longint unsigned   ts;
    bit                wrap;
  } ment_t;

  ment_t             mq[$];
  longint unsigned   m_ts;
  bit                m_wrap, m_armed, started;
  logic [DATA_W-1:0] m_last;
  int unsigned       m_drops;

  initial started = 1'b0;

  always @(posedge clk) begin
    bit do_pop, chg, acc;
    if (rst) begin
      mq.delete();
      m_ts    = 0;
      m_wrap  = 1'b0;
      m_armed = 1'b1;
      m_last  = '0;
      m_drops = 0;
      started = 1'b1;
    end else if (started) begin
      do_pop = (mq.size() != 0) && out_ready;
      chg    = sample_valid && (m_armed || (sample_in != m_last));
      acc    = chg && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) mq.delete(0);
      if (acc) begin
        mq.push_back('{data: sample_in, ts: m_ts, wrap: m_wrap});
        m_wrap = 1'b0;
      end else if (chg && m_drops < (1 << DROP_W) - 1) begin
        m_drops++;
      end
      if (chg) begin
        m_last  = sample_in;
        m_armed = 1'b0;
      end
      if (ts_clear) begin
        m_ts   = 0;
        m_wrap = 1'b1;
      end else if (ts_en) begin
        m_ts = m_ts + TICK;
        if (m_ts >= (64'd1 << TS_W)) begin
          m_ts   = m_ts - (64'd1 << TS_W);
          m_wrap = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("fifo_level", 64'(fifo_level), 64'(mq.size()));
      check("ts_now", 64'(ts_now), m_ts);
      if (mq.size() != 0) begin
        check("out_data", 64'(out_data), 64'(mq[0].data));
        check("out_ts", 64'(out_ts), mq[0].ts);
        check("out_wrap", 64'(out_wrap), 64'(mq[0].wrap));
      end
`ifdef CHANGE_STAMP_DROP_CNT_EN
      check("drop_count", 64'(drop_count), 64'(m_drops));
`endif
    end
  end

  initial begin
    int unsigned thr;
    rst = 1'b1; ts_en = 1'b0; ts_clear = 1'b0; sample_valid = 1'b0;
    sample_in = '0; out_ready = 1'b0;
    s_rst = 1'b1; s_en = 1'b0; s_clear = 1'b0; s_valid = 1'b0;
    s_in = '0; s_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ts_now", 64'(ts_now), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ts", 64'(out_ts), 64'd0);
    rst = 1'b0; s_rst = 1'b0;

    // 10-bit timestamp: changes on three consecutive cycles
    s_en = 1'b1; s_ready = 1'b1; s_valid = 1'b1; s_in = 32'd5;
    @(negedge clk);
    check("w10_e0_data", 64'(s_out_data), 64'd5);
    check("w10_e0_ts", 64'(s_out_ts), 64'd0);
    check("w10_e0_wrap", 64'(s_out_wrap), 64'd0);
    s_in = 32'd6;
    @(negedge clk);
    check("w10_e1_ts", 64'(s_out_ts), 64'd552);
    check("w10_e1_wrap", 64'(s_out_wrap), 64'd0);
    s_in = 32'd7;
    @(negedge clk);
    check("w10_e2_data", 64'(s_out_data), 64'd7);
    check("w10_e2_ts", 64'(s_out_ts), 64'd80);
    check("w10_e2_wrap", 64'(s_out_wrap), 64'd1);
    s_valid = 1'b0; s_en = 1'b0;

    // Two changes, drained immediately
    ts_en = 1'b1; out_ready = 1'b1; sample_valid = 1'b1; sample_in = 32'd1;
    @(negedge clk);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_data", 64'(out_data), 64'd1);
    check("first_ts", 64'(out_ts), 64'd0);
    sample_in = 32'd11;
    @(negedge clk);
    check("second_data", 64'(out_data), 64'd11);
    check("second_ts", 64'(out_ts), 64'd552);

    // Repeated value produces no entries
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("repeat_level", 64'(fifo_level), 64'd0);
    end

    // Burst of 10 distinct values with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample_in = 32'(100 + i);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    check("burst_level", 64'(fifo_level), 64'd8);
    check("burst_head", 64'(out_data), 64'd100);
`ifdef CHANGE_STAMP_DROP_CNT_EN
    check("burst_drops", 64'(drop_count), 64'd2);
`endif

    // Full FIFO, pop and push in the same cycle
    out_ready = 1'b1; sample_valid = 1'b1; sample_in = 32'd200;
    @(negedge clk);
    sample_valid = 1'b0;
    check("full_swap_level", 64'(fifo_level), 64'd8);
    check("full_swap_head", 64'(out_data), 64'd101);
`ifdef CHANGE_STAMP_DROP_CNT_EN
    check("full_swap_drops", 64'(drop_count), 64'd2);
`endif
    repeat (8) @(negedge clk);

    // Reset with a backlog pending
    out_ready = 1'b0; sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample_in = 32'(300 + i);
      @(negedge clk);
    end
    sample_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_ts", 64'(ts_now), 64'd0);
    rst = 1'b0; sample_valid = 1'b1; sample_in = 32'd304;
    @(negedge clk);
    check("rearm_valid", 64'(out_valid), 64'd1);
    check("rearm_data", 64'(out_data), 64'd304);
    check("rearm_ts", 64'(out_ts), 64'd0);

    // Randomized traffic
    thr = 5;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) thr = $urandom_range(1, 10);
      rst          = ($urandom_range(0, 299) == 0);
      ts_en        = ($urandom_range(0, 9) != 0);
      ts_clear     = ($urandom_range(0, 39) == 0);
      sample_valid = ($urandom_range(0, 9) < 6);
      sample_in    = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 3));
      out_ready    = ($urandom_range(0, 9) < thr);
      @(negedge clk);
    end
    rst = 1'b0; sample_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
